// File: rtl/debounce_pkg.sv
// Shared FSM encodings and helpers for the debounce / edge-detect block and its checkers.
// Encoding keeps bit 1 as the committed level; the WAIT states are the odd-parity codes.
package debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE_LOW  = 2'b00;
    localparam state_t WAIT_HIGH = 2'b01;
    localparam state_t IDLE_HIGH = 2'b11;
    localparam state_t WAIT_LOW  = 2'b10;

    function automatic logic is_wait(input state_t s);
        return (s == WAIT_HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/debounce_timer.sv
// Stability counter: clears to 0, counts up while enabled, flags DEBOUNCE_CYCLES-1.
// Single register, terminal-count flag is combinational from the count.
module debounce_timer #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounces a synchronised level; emits clean level, 1-cycle rise/fall pulses and a rise count.
// A new level commits DEBOUNCE_CYCLES edges after the edge that first samples it; no backpressure.
module debounce_edge_detect
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10,
    parameter int EVT_W           = 8
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             sync_in,
    input  logic             evt_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy,
    output logic [EVT_W-1:0] evt_count
);

    state_t           state;
    state_t           state_nxt;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_tc;
    logic [CNT_W-1:0] tmr_cnt;
    logic             rise_commit;
    logic             fall_commit;

    debounce_timer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_timer (
        .clk         (clk),
        .async_reset (async_reset),
        .clr         (tmr_clr),
        .en          (tmr_en),
        .cnt         (tmr_cnt),
        .tc          (tmr_tc)
    );

    // Timer is held cleared everywhere except while a candidate level keeps holding.
    always_comb begin
        state_nxt   = state;
        tmr_clr     = 1'b1;
        tmr_en      = 1'b0;
        rise_commit = 1'b0;
        fall_commit = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (sync_in) state_nxt = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!sync_in) begin
                    state_nxt = IDLE_LOW;
                end else if (tmr_tc) begin
                    state_nxt   = IDLE_HIGH;
                    rise_commit = 1'b1;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!sync_in) state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_nxt = IDLE_HIGH;
                end else if (tmr_tc) begin
                    state_nxt   = IDLE_LOW;
                    fall_commit = 1'b1;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            default: state_nxt = IDLE_LOW;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state      <= IDLE_LOW;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rise_pulse <= rise_commit;
            fall_pulse <= fall_commit;
            busy       <= is_wait(state_nxt);
            if (rise_commit) begin
                level_out <= 1'b1;
            end else if (fall_commit) begin
                level_out <= 1'b0;
            end
        end
    end

    // A clear coinciding with a rise commit still counts that rise.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            evt_count <= '0;
        end else if (evt_clr) begin
            evt_count <= rise_commit ? EVT_W'(1) : '0;
        end else if (rise_commit) begin
            evt_count <= evt_count + EVT_W'(1);
        end
    end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench: N=4 instance for the main sequence, N=1 instance for minimum latency.
module tb_debounce_edge_detect;

    logic       clk = 1'b0;
    logic       async_reset;
    logic       sync_in;
    logic       evt_clr;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       busy;
    logic [3:0] evt_count;

    logic       sync_in_b;
    logic       evt_clr_b;
    logic       level_out_b;
    logic       rise_pulse_b;
    logic       fall_pulse_b;
    logic       busy_b;
    logic [3:0] evt_count_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debounce_edge_detect #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (10),
        .EVT_W           (4)
    ) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .sync_in     (sync_in),
        .evt_clr     (evt_clr),
        .level_out   (level_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .busy        (busy),
        .evt_count   (evt_count)
    );

    debounce_edge_detect #(
        .DEBOUNCE_CYCLES (1),
        .CNT_W           (10),
        .EVT_W           (4)
    ) dut_n1 (
        .clk         (clk),
        .async_reset (async_reset),
        .sync_in     (sync_in_b),
        .evt_clr     (evt_clr_b),
        .level_out   (level_out_b),
        .rise_pulse  (rise_pulse_b),
        .fall_pulse  (fall_pulse_b),
        .busy        (busy_b),
        .evt_count   (evt_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a level and hold it through the full qualification window of the N=4 instance.
    task automatic commit_level(input logic lvl);
        sync_in = lvl;
        step(5);
    endtask

    // Pulses must be one-hot and last a single cycle on both instances.
    logic prev_rise = 1'b0, prev_fall = 1'b0, prev_rise_b = 1'b0, prev_fall_b = 1'b0;
    always @(negedge clk) begin
        chk("pulse_onehot", {31'd0, rise_pulse & fall_pulse}, 32'd0);
        chk("pulse_onehot_n1", {31'd0, rise_pulse_b & fall_pulse_b}, 32'd0);
        chk("pulse_single", {31'd0, (rise_pulse & prev_rise) | (fall_pulse & prev_fall)}, 32'd0);
        chk("pulse_single_n1", {31'd0, (rise_pulse_b & prev_rise_b) | (fall_pulse_b & prev_fall_b)}, 32'd0);
        prev_rise   = rise_pulse;
        prev_fall   = fall_pulse;
        prev_rise_b = rise_pulse_b;
        prev_fall_b = fall_pulse_b;
    end

    initial begin
        async_reset = 1'b1;
        sync_in     = 1'b0;
        evt_clr     = 1'b0;
        sync_in_b   = 1'b0;
        evt_clr_b   = 1'b0;
        #12;
        chk("rst_level", level_out, 0);
        chk("rst_rise", rise_pulse, 0);
        chk("rst_fall", fall_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_evt", evt_count, 0);
        async_reset = 1'b0;
        step(2);
        chk("idle_busy", busy, 0);

        // 1: clean rise, commit on edge 5
        sync_in = 1'b1;
        step(1);
        chk("t1_busy_e1", busy, 1);
        chk("t1_level_e1", level_out, 0);
        step(3);
        chk("t1_level_e4", level_out, 0);
        chk("t1_rise_e4", rise_pulse, 0);
        chk("t1_busy_e4", busy, 1);
        step(1);
        chk("t1_level_e5", level_out, 1);
        chk("t1_rise_e5", rise_pulse, 1);
        chk("t1_busy_e5", busy, 0);
        chk("t1_evt", evt_count, 1);
        step(1);
        chk("t1_rise_e6", rise_pulse, 0);
        chk("t1_level_e6", level_out, 1);

        // 3: clean fall, evt_count unchanged
        sync_in = 1'b0;
        step(1);
        chk("t3_busy_e1", busy, 1);
        step(3);
        chk("t3_fall_e4", fall_pulse, 0);
        chk("t3_level_e4", level_out, 1);
        step(1);
        chk("t3_fall_e5", fall_pulse, 1);
        chk("t3_level_e5", level_out, 0);
        chk("t3_evt", evt_count, 1);
        step(1);
        chk("t3_fall_e6", fall_pulse, 0);

        // 2: bounce high 2, low 1, then high 4+
        sync_in = 1'b1;
        step(2);
        chk("t2_burst_busy", busy, 1);
        sync_in = 1'b0;
        step(1);
        chk("t2_abandon_busy", busy, 0);
        chk("t2_abandon_rise", rise_pulse, 0);
        sync_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk("t2_no_early_rise", rise_pulse, 0);
        end
        step(1);
        chk("t2_rise_e5", rise_pulse, 1);
        chk("t2_level", level_out, 1);
        chk("t2_evt", evt_count, 2);

        // 4: wrap evt_count
        for (int i = 0; i < 13; i++) begin
            commit_level(1'b0);
            commit_level(1'b1);
        end
        chk("t4_evt15", evt_count, 15);
        commit_level(1'b0);
        commit_level(1'b1);
        chk("t4_evt_wrap", evt_count, 0);
        commit_level(1'b0);
        sync_in = 1'b1;
        step(4);
        evt_clr = 1'b1;
        step(1);
        evt_clr = 1'b0;
        chk("t4_clr_rise_pulse", rise_pulse, 1);
        chk("t4_clr_with_rise", evt_count, 1);

        // 5: async reset mid-WAIT_HIGH with cnt=2
        commit_level(1'b0);
        chk("t5_evt_before", evt_count, 1);
        sync_in = 1'b1;
        step(3);
        chk("t5_busy_pre", busy, 1);
        #3;
        async_reset = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_level", level_out, 0);
        chk("t5_rst_rise", rise_pulse, 0);
        chk("t5_rst_evt", evt_count, 0);
        step(1);
        chk("t5_hold_rise", rise_pulse, 0);
        async_reset = 1'b0;
        step(1);
        chk("t5_rel_busy_e1", busy, 1);
        step(3);
        chk("t5_rel_rise_e4", rise_pulse, 0);
        step(1);
        chk("t5_rel_rise_e5", rise_pulse, 1);
        chk("t5_rel_level", level_out, 1);
        chk("t5_rel_evt", evt_count, 1);
        evt_clr = 1'b1;
        step(1);
        evt_clr = 1'b0;
        chk("t5_clr_alone", evt_count, 0);

        // 6: N=1 instance
        chk("t6_idle_level", level_out_b, 0);
        sync_in_b = 1'b1;
        step(1);
        chk("t6_busy_e1", busy_b, 1);
        chk("t6_rise_e1", rise_pulse_b, 0);
        step(1);
        chk("t6_rise_e2", rise_pulse_b, 1);
        chk("t6_level_e2", level_out_b, 1);
        chk("t6_evt", evt_count_b, 1);
        step(1);
        chk("t6_rise_e3", rise_pulse_b, 0);
        sync_in_b = 1'b0;
        step(2);
        chk("t6_fall_e2", fall_pulse_b, 1);
        chk("t6_fall_level", level_out_b, 0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
